// File: rtl/opl3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opl3_mem_pkg
// Purpose  : Shared types, constants and width helpers for the OPL3 RAM
//            write scheduler and its round-robin arbiter.
// Contents : state_e          - scheduler state encoding (IDLE / CLEAR)
//            DEFAULT_CLEAR_VALUE - word written to every address on a clear
//            calc_aw / calc_iw   - address and requester-index widths
// Revision : 1.0 - initial release
// ============================================================================
package opl3_mem_pkg;

  localparam int unsigned DEFAULT_CLEAR_VALUE = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Address width; a one-word RAM still gets a 1-bit address.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Requester index width; a single requester still gets a 1-bit index.
  function automatic int unsigned calc_iw(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opl3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : opl3_rr_arbiter
// Purpose  : Purely combinational round-robin arbiter. The search starts one
//            position after the previous winner and wraps modulo NUM_REQ.
// Ports    : req_i   [NUM_REQ] in  - request vector
//            last_i  [IW]      in  - index of the previous winner
//            grant_o [NUM_REQ] out - one-hot grant (zero if no request)
//            idx_o   [IW]      out - encoded index of the grant
//            valid_o           out - some request was granted
// Revision : 1.0 - initial release
// ============================================================================
module opl3_rr_arbiter
  import opl3_mem_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = calc_iw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  int unsigned cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    // k runs 1..NUM_REQ so the previous winner is examined last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_i) + k) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/opl3_mem_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : opl3_mem_write_scheduler
// Purpose  : Owns the write port of one simple dual-port RAM. Shares it among
//            NUM_REQ requesters by round-robin valid/ready arbitration and
//            sweeps CLEAR_VALUE through every address after reset and on
//            clear_start.
// Ports    : clk, reset_n (async, active low)
//            clear_start in  - pulse to start a full clear (IDLE only)
//            clear_busy  out - clear sweep in progress
//            req_valid/req_addr/req_data in, req_ready out - requester side
//            wea/addra/dia out - registered RAM write port
//            last_grant  out - most recently accepted requester
// Revision : 1.0 - initial release
// ============================================================================
module opl3_mem_write_scheduler
  import opl3_mem_pkg::*;
#(
  parameter  int unsigned            DATA_WIDTH  = 8,
  parameter  int unsigned            DEPTH       = 256,
  parameter  int unsigned            NUM_REQ     = 2,
  parameter  logic [DATA_WIDTH-1:0]  CLEAR_VALUE = DATA_WIDTH'(DEFAULT_CLEAR_VALUE),
  localparam int unsigned            AW          = calc_aw(DEPTH),
  localparam int unsigned            IW          = calc_iw(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear_start,
  output logic                          clear_busy,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*AW-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wea,
  output logic [AW-1:0]                 addra,
  output logic [DATA_WIDTH-1:0]         dia,
  output logic [IW-1:0]                 last_grant
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_REQ   = IW'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           clear_ptr_q, clear_ptr_d;
  logic                    wea_q, wea_d;
  logic [AW-1:0]           addra_q, addra_d;
  logic [DATA_WIDTH-1:0]   dia_q, dia_d;
  logic [IW-1:0]           last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IW-1:0]           arb_idx;
  logic                    arb_valid;
  logic                    arb_en;
  logic                    accept;
  logic                    ptr_at_end;

  opl3_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req_valid),
    .last_i  (last_grant_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // A clear request in the same cycle takes priority over any write.
  assign arb_en     = (state_q == ST_IDLE) && !clear_start;
  assign req_ready  = arb_en ? arb_grant : '0;
  assign accept     = arb_en && arb_valid;
  assign ptr_at_end = (clear_ptr_q == LAST_ADDR);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (ptr_at_end)  state_d = ST_IDLE;
      ST_IDLE:  if (clear_start) state_d = ST_CLEAR;
      default:                   state_d = ST_CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    clear_busy = (state_q == ST_CLEAR);
  end

  // ---------------- Datapath next values ----------------
  always_comb begin
    clear_ptr_d  = '0;
    wea_d        = 1'b0;
    addra_d      = addra_q;
    dia_d        = dia_q;
    last_grant_d = last_grant_q;
    if (state_q == ST_CLEAR) begin
      wea_d   = 1'b1;
      addra_d = clear_ptr_q;
      dia_d   = CLEAR_VALUE;
      // Wrapping to zero on the last address keeps the pointer below DEPTH.
      if (!ptr_at_end) clear_ptr_d = clear_ptr_q + 1'b1;
    end else if (accept) begin
      wea_d        = 1'b1;
      addra_d      = req_addr[arb_idx*AW +: AW];
      dia_d        = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      last_grant_d = arb_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_ptr_q  <= '0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dia_q        <= '0;
      last_grant_q <= LAST_REQ;
    end else begin
      clear_ptr_q  <= clear_ptr_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dia_q        <= dia_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wea        = wea_q;
  assign addra      = addra_q;
  assign dia        = dia_q;
  assign last_grant = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_opl3_mem_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_opl3_mem_write_scheduler
// Purpose  : Self-checking bench for opl3_mem_write_scheduler. A DEPTH=256
//            instance is checked cycle by cycle against a behavioural model;
//            a DEPTH=200 instance shares clock/reset to check the sweep range.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opl3_mem_write_scheduler;

  localparam int DW = 8, DEPTH = 256, NR = 2, AW = 8, IW = 1, DEPTH2 = 200;

  logic clk = 1'b0, reset_n = 1'b0, clear_start = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             clear_busy, wea;
  logic [NR-1:0]    req_ready;
  logic [AW-1:0]    addra;
  logic [DW-1:0]    dia;
  logic [IW-1:0]    last_grant;

  // second instance: non-power-of-two depth, requests tied idle
  logic             clear_start2 = 1'b0;
  logic [NR-1:0]    req_valid2 = '0;
  logic [NR*AW-1:0] req_addr2 = '0;
  logic [NR*DW-1:0] req_data2 = '0;
  logic             clear_busy2, wea2;
  logic [NR-1:0]    req_ready2;
  logic [AW-1:0]    addra2;
  logic [DW-1:0]    dia2;
  logic [IW-1:0]    last_grant2;

  always #5 clk = ~clk;

  opl3_mem_write_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR), .CLEAR_VALUE(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .clear_start(clear_start), .clear_busy(clear_busy),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wea(wea), .addra(addra), .dia(dia), .last_grant(last_grant));

  opl3_mem_write_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH2), .NUM_REQ(NR), .CLEAR_VALUE(8'h00)) dut200 (
    .clk(clk), .reset_n(reset_n), .clear_start(clear_start2), .clear_busy(clear_busy2),
    .req_valid(req_valid2), .req_addr(req_addr2), .req_data(req_data2), .req_ready(req_ready2),
    .wea(wea2), .addra(addra2), .dia(dia2), .last_grant(last_grant2));

  // RAM behind the write port; dob = ram[addrb] (async read)
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (wea) ram[addra] <= dia;

  int vectors = 0, miscompares = 0;

  // ---------------- reference model ----------------
  bit            m_clear;
  int            m_ptr, m_last;
  logic          e_wea;
  logic [AW-1:0] e_addra;
  logic [DW-1:0] e_dia;
  logic [NR-1:0] exp_ready, obs_ready;
  logic          exp_busy, obs_busy;
  logic [AW+DW+IW:0] exp_out, obs_out;

  task automatic model_reset();
    m_clear = 1; m_ptr = 0; m_last = NR - 1;
    e_wea = 0; e_addra = '0; e_dia = '0;
  endtask

  // Grant rule: nothing while clearing or when a clear is requested;
  // otherwise the first valid requester after the last winner, wrapping.
  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] r;
    r = '0;
    if (!m_clear && !clear_start)
      for (int k = 1; k <= NR; k++)
        if (r == '0 && req_valid[(m_last + k) % NR]) r[(m_last + k) % NR] = 1'b1;
    return r;
  endfunction

  task automatic model_commit(input logic [NR-1:0] rdy);
    if (m_clear) begin
      e_wea = 1; e_addra = AW'(m_ptr); e_dia = 8'h00;
      m_ptr++;
      if (m_ptr == DEPTH) begin m_clear = 0; m_ptr = 0; end
    end else if (clear_start) begin
      m_clear = 1; m_ptr = 0; e_wea = 0;
    end else if (rdy != '0) begin
      for (int i = 0; i < NR; i++)
        if (rdy[i]) begin
          e_wea = 1; e_addra = req_addr[i*AW +: AW]; e_dia = req_data[i*DW +: DW]; m_last = i;
        end
    end else begin
      e_wea = 0;
    end
  endtask

  // One clock: capture ready/busy at negedge, outputs 1 ns after the edge.
  task automatic tick();
    @(negedge clk);
    exp_ready = model_ready();
    exp_busy  = m_clear;
    obs_ready = req_ready;
    obs_busy  = clear_busy;
    @(posedge clk); #1;
    model_commit(exp_ready);
    exp_out = {e_wea, e_addra, e_dia, IW'(m_last)};
    obs_out = {wea, addra, dia, last_grant};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0; req_valid = 2'b11;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({clear_busy, req_ready, wea, addra, dia, last_grant} !== {1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b rdy=%b wea=%b addr=%h dia=%h lg=%0d, want 1 00 0 00 00 1",
               clear_busy, req_ready, wea, addra, dia, last_grant);
    end
    vectors++;
    if ({clear_busy2, wea2, addra2} !== {1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state200: got busy=%b wea=%b addr=%h, want 1 0 00", clear_busy2, wea2, addra2);
    end
    req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic test_clear_sweep();
    int busy_cnt = 0, wea2_cnt = 0, bad2 = 0;
    for (int n = 0; n < 262; n++) begin
      tick();
      if (obs_busy) busy_cnt++;
      if (wea2) begin wea2_cnt++; if (addra2 >= DEPTH2) bad2++; end
      vectors++;
      if (obs_busy !== exp_busy || obs_ready !== exp_ready || obs_out !== exp_out) begin
        miscompares++;
        $display("FAIL sweep n=%0d: got busy=%b rdy=%b out=%h, want busy=%b rdy=%b out=%h",
                 n, obs_busy, obs_ready, obs_out, exp_busy, exp_ready, exp_out);
      end
    end
    vectors++;
    if (busy_cnt != DEPTH) begin
      miscompares++; $display("FAIL sweep_len: got %0d busy cycles, want %0d", busy_cnt, DEPTH);
    end
    vectors++;
    if (wea2_cnt != DEPTH2 || bad2 != 0) begin
      miscompares++;
      $display("FAIL sweep200: got %0d writes (%0d out of range), want %0d (0)", wea2_cnt, bad2, DEPTH2);
    end
    vectors++;
    if ({clear_busy, wea, clear_busy2, wea2} !== 4'b0000) begin
      miscompares++;
      $display("FAIL sweep_end: got busy=%b wea=%b busy200=%b wea200=%b, want 0 0 0 0", clear_busy, wea, clear_busy2, wea2);
    end
  endtask

  task automatic test_alternate();
    int order [4] = '{0, 1, 0, 1};
    req_addr = {8'h20, 8'h10}; req_data = {8'h5A, 8'hA5}; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (obs_ready !== exp_ready || obs_out !== exp_out || last_grant !== IW'(order[k]) || wea !== 1'b1) begin
        miscompares++;
        $display("FAIL alternate k=%0d: got rdy=%b out=%h lg=%0d, want rdy=%b out=%h lg=%0d",
                 k, obs_ready, obs_out, last_grant, exp_ready, exp_out, order[k]);
      end
    end
    req_valid = '0;
    tick();
    vectors++;
    if (ram[8'h10] !== 8'hA5 || ram[8'h20] !== 8'h5A) begin
      miscompares++;
      $display("FAIL alternate_ram: got [10]=%h [20]=%h, want A5 5A", ram[8'h10], ram[8'h20]);
    end
  endtask

  task automatic test_single();
    req_addr = {8'h07, 8'h00};
    req_valid = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      req_data = {DW'(k), 8'h00};
      tick();
      vectors++;
      if (obs_ready !== 2'b10 || obs_out !== exp_out || {wea, addra, dia} !== {1'b1, 8'h07, DW'(k)}) begin
        miscompares++;
        $display("FAIL single k=%0d: got rdy=%b out=%h, want rdy=10 out=%h", k, obs_ready, obs_out, exp_out);
      end
    end
    req_valid = '0;
    tick();
    vectors++;
    if (obs_out !== exp_out || {wea, addra, dia} !== {1'b0, 8'h07, 8'h03}) begin
      miscompares++;
      $display("FAIL single_hold: got out=%h, want wea=0 addr=07 dia=03 (%h)", obs_out, exp_out);
    end
    tick();
    vectors++;
    if (ram[7] !== 8'h03) begin
      miscompares++; $display("FAIL single_ram: got RAM[7]=%h, want 03", ram[7]);
    end
  endtask

  task automatic test_clear_collision();
    int clr_cnt = 0;
    req_addr = {8'h00, 8'h33}; req_data = {8'h00, 8'h77};
    req_valid = 2'b01; clear_start = 1;
    tick();
    clear_start = 0;
    vectors++;
    if (obs_ready !== 2'b00 || obs_out !== exp_out || wea !== 1'b0) begin
      miscompares++;
      $display("FAIL collide: got rdy=%b out=%h, want rdy=00 out=%h", obs_ready, obs_out, exp_out);
    end
    for (int n = 0; n < 300 && m_clear; n++) begin
      clear_start = (n == 50);  // ignored while sweeping
      tick();
      clear_start = 0;
      clr_cnt++;
      vectors++;
      if (obs_ready !== exp_ready || obs_busy !== exp_busy || obs_out !== exp_out) begin
        miscompares++;
        $display("FAIL collide_clear n=%0d: got rdy=%b busy=%b out=%h, want %b %b %h",
                 n, obs_ready, obs_busy, obs_out, exp_ready, exp_busy, exp_out);
      end
    end
    vectors++;
    if (clr_cnt != DEPTH) begin
      miscompares++; $display("FAIL collide_len: got %0d clear cycles, want %0d", clr_cnt, DEPTH);
    end
    tick();
    req_valid = '0;
    vectors++;
    if (obs_ready !== 2'b01 || obs_out !== exp_out || {wea, addra, dia} !== {1'b1, 8'h33, 8'h77}) begin
      miscompares++;
      $display("FAIL collide_serve: got rdy=%b out=%h, want rdy=01 out=%h", obs_ready, obs_out, exp_out);
    end
  endtask

  task automatic test_reset_mid_clear();
    int wcnt = 0, first = -1;
    bit seen [DEPTH];
    clear_start = 1;
    tick();
    clear_start = 0;
    repeat (100) tick();
    #2 reset_n = 0;
    #1;
    vectors++;
    if ({clear_busy, req_ready, wea, addra, dia, last_grant} !== {1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset: got busy=%b rdy=%b wea=%b addr=%h dia=%h lg=%0d, want 1 00 0 00 00 1",
               clear_busy, req_ready, wea, addra, dia, last_grant);
    end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
    for (int i = 0; i < DEPTH; i++) seen[i] = 0;
    for (int n = 0; n < DEPTH + 4; n++) begin
      tick();
      if (wea) begin
        wcnt++;
        if (first < 0) first = int'(addra);
        seen[addra] = 1;
      end
      vectors++;
      if (obs_out !== exp_out || obs_busy !== exp_busy) begin
        miscompares++;
        $display("FAIL midreset_sweep n=%0d: got busy=%b out=%h, want %b %h", n, obs_busy, obs_out, exp_busy, exp_out);
      end
    end
    for (int i = 0; i < DEPTH; i++) if (!seen[i]) wcnt = -1;
    vectors++;
    if (wcnt != DEPTH || first != 0) begin
      miscompares++;
      $display("FAIL midreset_cover: got %0d writes first=%0d, want %0d first=0", wcnt, first, DEPTH);
    end
  endtask

  task automatic test_random();
    req_valid = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && ($urandom % 2 == 0)) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom);
          req_data[i*DW +: DW] = DW'($urandom);
        end
      clear_start = ($urandom % 128 == 0);
      tick();
      clear_start = 0;
      vectors++;
      if (obs_ready !== exp_ready || obs_busy !== exp_busy || obs_out !== exp_out) begin
        miscompares++;
        $display("FAIL random n=%0d: got rdy=%b busy=%b out=%h, want %b %b %h",
                 n, obs_ready, obs_busy, obs_out, exp_ready, exp_busy, exp_out);
      end
      for (int i = 0; i < NR; i++) if (exp_ready[i]) req_valid[i] = 1'b0;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_alternate();
    test_single();
    test_clear_collision();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
